// File: rtl/compc_ctrl.sv
// Initiator side of the comparator enable/done handshake: packs {A,B}, runs enable/done, returns the result.
// Optional watchdog on the REQ/RELEASE wait enabled with `define COMPC_TIMEOUT_EN.
module compc_ctrl #(
  parameter int inputsize      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [inputsize-1:0]   a_in,
  input  logic [inputsize-1:0]   b_in,
  output logic                   busy,
  output logic [2*inputsize-1:0] data_out,
  output logic                   enable_out,
  input  logic                   done_in,
  input  logic [3:0]             ab_in,
  output logic [3:0]             result,
  output logic                   result_valid,
  output logic                   error
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;
  state_t state;

`ifdef COMPC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign error = 1'b0;
`endif

  // NOTE: every register here, outputs included, uses non-blocking assignment and the
  // asynchronous reset so enable_out drops the moment rst rises, whatever the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      data_out     <= '0;
      enable_out   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef COMPC_TIMEOUT_EN
      error        <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
`ifdef COMPC_TIMEOUT_EN
      if (state == REQ || state == RELEASE) wd_cnt <= wd_cnt + 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            data_out <= {a_in, b_in};
            busy     <= 1'b1;
`ifdef COMPC_TIMEOUT_EN
            error    <= 1'b0;
`endif
            state    <= SETUP;
          end
        end
        SETUP: begin
`ifdef COMPC_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state  <= REQ;
        end
        REQ: begin
          // done is only trusted once the unit has actually seen enable high.
          if (enable_out && done_in) begin
            result     <= ab_in;
            enable_out <= 1'b0;
            state      <= RELEASE;
          end
`ifdef COMPC_TIMEOUT_EN
          else if (wd_hit) begin
            error      <= 1'b1;
            enable_out <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
`endif
          else begin
            enable_out <= 1'b1;
          end
        end
        RELEASE: begin
          if (!done_in) begin
            busy         <= 1'b0;
            result_valid <= 1'b1;
            state        <= IDLE;
          end
`ifdef COMPC_TIMEOUT_EN
          else if (wd_hit) begin
            error      <= 1'b1;
            enable_out <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compc_ctrl.sv
// Directed bench for compc_ctrl with a small enable/done unit model (delay, stuck-done options).
// Build with +define+COMPC_TIMEOUT_EN to exercise the watchdog path.
module tb_compc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       busy;
  logic [7:0] data_out;
  logic       enable_out;
  logic       done_in;
  logic [3:0] ab_in;
  logic [3:0] result;
  logic       result_valid;
  logic       error;

  compc_ctrl #(.inputsize(4), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .data_out(data_out), .enable_out(enable_out),
    .done_in(done_in), .ab_in(ab_in), .result(result),
    .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  // Unit model: done follows enable after unit_delay cycles; drops with enable.
  int   unit_delay = 0;
  logic unit_stuck = 1'b0;
  logic [3:0] unit_ab = 4'd0;
  int   hi_cnt;
  always @(posedge clk or posedge rst)
    if (rst) hi_cnt <= 0;
    else     hi_cnt <= enable_out ? hi_cnt + 1 : 0;
  assign done_in = !unit_stuck && enable_out && (hi_cnt >= unit_delay);
  assign ab_in   = unit_ab;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally result_valid pulses.
  task automatic step();
    @(negedge clk);
    if (result_valid) vcnt++;
  endtask

  task automatic start_txn(input logic [3:0] a, input logic [3:0] b);
    a_in = a; b_in = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!result_valid && n < budget) begin
      step();
      n++;
    end
    check("valid_wait", result_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "bench time limit");
  end

  initial begin
    int en_hi, bad;
    rst = 1'b1; start = 1'b0; a_in = 4'd0; b_in = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_en", enable_out, 0);
    check("rst_result", result, 4'd0);
    check("rst_valid", result_valid, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    step();

    // Equal operands, immediate unit: exact latency.
    unit_delay = 0; unit_ab = 4'd1; vcnt = 0;
    start_txn(4'd5, 4'd5);
    check("eq_data", data_out, 8'h55);
    check("eq_busy", busy, 1);
    check("eq_en_e0", enable_out, 0);
    step(); check("eq_en_e1", enable_out, 0);
    step(); check("eq_en_e2", enable_out, 1);
    step(); check("eq_en_e3", enable_out, 0);
    check("eq_result", result, 4'd1);
    check("eq_valid_e3", result_valid, 0);
    step(); check("eq_valid_e4", result_valid, 1);
    check("eq_busy_e4", busy, 0);
    step(); check("eq_valid_e5", result_valid, 0);
    check("eq_vcnt", vcnt, 1);

    // Unequal operands with extra starts while busy.
    unit_ab = 4'd0; vcnt = 0;
    start_txn(4'd3, 4'd9);
    a_in = 4'd7; b_in = 4'd7;
    start = 1'b1; step(); start = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    wait_valid(20);
    check("ne_data", data_out, 8'h39);
    check("ne_result", result, 4'd0);
    repeat (5) step();
    check("ne_busy", busy, 0);
    check("ne_vcnt", vcnt, 1);

    // Slow unit: enable held until done, data stable.
    unit_delay = 6; unit_ab = 4'd2; vcnt = 0;
    start_txn(4'd2, 4'd12);
    en_hi = 0; bad = 0;
    for (int n = 0; n < 40 && !result_valid; n++) begin
      if (enable_out) en_hi++;
      if (data_out !== 8'h2c) bad++;
      step();
    end
    check("slow_valid", result_valid, 1);
    check("slow_en_cycles", en_hi, 7);
    check("slow_data_stable", bad, 0);
    check("slow_result", result, 4'd2);

    // Back-to-back with start held high.
    unit_delay = 0; unit_ab = 4'd3; vcnt = 0;
    a_in = 4'd4; b_in = 4'd6; start = 1'b1;
    step(); check("b2b_data1", data_out, 8'h46);
    repeat (3) step();
    step(); check("b2b_valid1", result_valid, 1);
    check("b2b_busy_gap", busy, 0);
    a_in = 4'd1; b_in = 4'd8;
    step(); check("b2b_data2", data_out, 8'h18);
    check("b2b_busy2", busy, 1);
    start = 1'b0;
    wait_valid(20);
    check("b2b_result", result, 4'd3);
    check("b2b_vcnt", vcnt, 2);
    step();

    // Reset mid-operation.
    unit_delay = 6; vcnt = 0;
    start_txn(4'd9, 4'd9);
    repeat (3) step();
    check("mrst_en_before", enable_out, 1);
    rst = 1'b1;
    #1;
    check("mrst_en", enable_out, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", data_out, 8'h00);
    check("mrst_result", result, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) step();
    check("mrst_vcnt", vcnt, 0);
    check("mrst_busy_after", busy, 0);

    // Unit never answers.
    unit_stuck = 1'b1; unit_ab = 4'd5; vcnt = 0;
    start_txn(4'd6, 4'd1);
`ifdef COMPC_TIMEOUT_EN
    repeat (15) step();
    check("to_error_early", error, 0);
    check("to_en_early", enable_out, 1);
    step();
    check("to_error", error, 1);
    check("to_en", enable_out, 0);
    check("to_busy", busy, 0);
    check("to_result", result, 4'd0);
    check("to_vcnt", vcnt, 0);
    unit_stuck = 1'b0; unit_ab = 4'd1; unit_delay = 0;
    start_txn(4'd5, 4'd5);
    check("to_error_clear", error, 0);
    wait_valid(20);
    check("to_recover_result", result, 4'd1);
`else
    repeat (30) step();
    check("nto_busy", busy, 1);
    check("nto_en", enable_out, 1);
    check("nto_error", error, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    unit_stuck = 1'b0;
    step();
    check("nto_busy_after_rst", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
